// File: rtl/aes_key_expander_multi.sv
// AES-128/192/256 key schedule: one 32-bit word per cycle into a 60-word table,
// with an in-order round-key stream and a 1-cycle random read port; no backpressure.

module aes_sbox (
    input  logic [7:0] a_i,
    output logic [7:0] s_o
);
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int n = 0; n < 8; n++) begin
            if (b[n]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // GF(2^8) inverse as a^254 (0 maps to 0), followed by the affine map.
    logic [7:0] x2, x4, x8, x16, x32, x64, x128, inv;
    assign x2   = gmul(a_i, a_i);
    assign x4   = gmul(x2, x2);
    assign x8   = gmul(x4, x4);
    assign x16  = gmul(x8, x8);
    assign x32  = gmul(x16, x16);
    assign x64  = gmul(x32, x32);
    assign x128 = gmul(x64, x64);
    assign inv  = gmul(gmul(gmul(x2, x4), gmul(x8, x16)), gmul(gmul(x32, x64), x128));
    assign s_o  = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                      ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

module aes_key_expander_multi #(
    parameter int MAX_KEY_W = 256,
    parameter int RK_W      = 128,
    parameter int MAX_WORDS = 60
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           key_len,
    input  logic [MAX_KEY_W-1:0] key,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic                 key_ready,
    output logic [3:0]           nr,
    output logic [RK_W-1:0]      out_key,
    output logic                 out_valid,
    output logic [3:0]           out_round,
    input  logic [3:0]           rk_addr,
    output logic [RK_W-1:0]      rk_data
);
    typedef enum logic {IDLE, EXPAND} state_t;

    state_t          state_q;
    logic [31:0]     w_q [0:MAX_WORDS-1];
    logic [3:0]      nk_q, nr_q, sp_q, oround_q, modc_q;
    logic [5:0]      i_q;
    logic [7:0]      rcon_q;
    logic            busy_q, done_q, err_q, kr_q, ovld_q;
    logic [RK_W-1:0] okey_q, rkd_q;

    logic            start_ok, start_bad, emit, rd_ok;
    logic [3:0]      nk_d, nr_d;
    logic [31:0]     temp, sub_in, sub_out, mix, new_word;
    logic [5:0]      base, rbase;
    logic [RK_W-1:0] stream_word, rd_word;

    assign temp   = w_q[i_q - 6'd1];
    assign sub_in = (modc_q == 4'd0) ? {temp[23:0], temp[31:24]} : temp;

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (.a_i(sub_in[8*b +: 8]), .s_o(sub_out[8*b +: 8]));
    end

    always_comb begin
        start_ok  = (state_q == IDLE) && start && (key_len != 2'b11);
        start_bad = (state_q == IDLE) && start && (key_len == 2'b11);
        case (key_len)
            2'b00:   begin nk_d = 4'd4; nr_d = 4'd10; end
            2'b01:   begin nk_d = 4'd6; nr_d = 4'd12; end
            default: begin nk_d = 4'd8; nr_d = 4'd14; end
        endcase
        mix = temp;
        if (modc_q == 4'd0)
            mix = sub_out ^ {rcon_q, 24'h000000};
        else if (nk_q == 4'd8 && modc_q == 4'd4)
            mix = sub_out;
        new_word = w_q[i_q - {2'b00, nk_q}] ^ mix;
        // A round streams once its last word is in the table; this also drains
        // the final round on the edge after the schedule returns to IDLE.
        base        = {sp_q, 2'b00};
        emit        = ((state_q != IDLE) || (sp_q <= nr_q)) && ({sp_q, 2'b11} < i_q);
        stream_word = {w_q[base], w_q[base + 6'd1], w_q[base + 6'd2], w_q[base + 6'd3]};
        rbase       = {rk_addr, 2'b00};
        rd_ok       = kr_q && (rk_addr <= nr_q);
        rd_word     = {w_q[rbase], w_q[rbase + 6'd1], w_q[rbase + 6'd2], w_q[rbase + 6'd3]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            nk_q     <= 4'd0;
            nr_q     <= 4'd0;
            sp_q     <= 4'd0;
            i_q      <= 6'd0;
            modc_q   <= 4'd0;
            rcon_q   <= 8'h01;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            kr_q     <= 1'b0;
            ovld_q   <= 1'b0;
            oround_q <= 4'd0;
            okey_q   <= '0;
            rkd_q    <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= start_bad;
            ovld_q <= emit;
            if (emit) begin
                okey_q   <= stream_word;
                oround_q <= sp_q;
            end
            sp_q  <= start_ok ? 4'd0 : (emit ? sp_q + 4'd1 : sp_q);
            rkd_q <= rd_ok ? rd_word : '0;
            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        nk_q    <= nk_d;
                        nr_q    <= nr_d;
                        i_q     <= {2'b00, nk_d};
                        modc_q  <= 4'd0;
                        rcon_q  <= 8'h01;
                        busy_q  <= 1'b1;
                        kr_q    <= 1'b0;
                        state_q <= EXPAND;
                    end
                end
                EXPAND: begin
                    i_q    <= i_q + 6'd1;
                    modc_q <= (modc_q == nk_q - 4'd1) ? 4'd0 : modc_q + 4'd1;
                    if (modc_q == 4'd0)
                        rcon_q <= {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
                    if (i_q == {nr_q, 2'b11}) begin
                        busy_q  <= 1'b0;
                        kr_q    <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Unused high key words for short modes are overwritten before they are read.
    always_ff @(posedge clk) begin
        if (start_ok) begin
            for (int j = 0; j < 8; j++)
                w_q[j] <= key[MAX_KEY_W-1-32*j -: 32];
        end else if (state_q == EXPAND) begin
            w_q[i_q] <= new_word;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign key_ready = kr_q;
    assign nr        = nr_q;
    assign out_key   = okey_q;
    assign out_valid = ovld_q;
    assign out_round = oround_q;
    assign rk_data   = rkd_q;
endmodule

// File: tb/tb_aes_key_expander_multi.sv
// Scoreboard bench for aes_key_expander_multi: table-driven reference schedule,
// known-answer rounds, handshake corners and reset mid-run.

module tb_aes_key_expander_multi;
    logic         clk = 1'b0;
    logic         rst, start;
    logic [1:0]   key_len;
    logic [255:0] key;
    logic [3:0]   rk_addr;
    logic         busy, done, err, key_ready, out_valid;
    logic [3:0]   nr, out_round;
    logic [127:0] out_key, rk_data;

    aes_key_expander_multi dut (
        .clk(clk), .rst(rst), .start(start), .key_len(key_len), .key(key),
        .busy(busy), .done(done), .err(err), .key_ready(key_ready), .nr(nr),
        .out_key(out_key), .out_valid(out_valid), .out_round(out_round),
        .rk_addr(rk_addr), .rk_data(rk_data)
    );

    always #5 clk = ~clk;

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [255:0] KLEG = 256'h642423baa95efb4362d3f2ce993c0904150f258aa1fe796841d7b4429c9b5a30;
    localparam logic [127:0] L128 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] L192 = 128'he98ba06f448c773c8ecc720401002202;
    localparam logic [127:0] L256 = 128'hfe4890d1e6188d0b046df344706c631e;

    logic [0:255][7:0] sbox_tab = {
        256'h637c777bf26b6fc53001672bfed7ab76ca82c97dfa5947f0add4a2af9ca472c0,
        256'hb7fd9326363ff7cc34a5e5f171d8311504c723c31896059a071280e2eb27b275,
        256'h09832c1a1b6e5aa0523bd6b329e32f8453d100ed20fcb15b6acbbe394a4c58cf,
        256'hd0efaafb434d338545f9027f503c9fa851a3408f929d38f5bcb6da2110fff3d2,
        256'hcd0c13ec5f974417c4a77e3d645d197360814fdc222a908846eeb814de5e0bdb,
        256'he0323a0a4906245cc2d3ac629195e479e7c8376d8dd54ea96c56f4ea657aae08,
        256'hba78252e1ca6b4c6e8dd741f4bbd8b8a703eb5664803f60e613557b986c11d9e,
        256'he1f8981169d98e949b1e87e9ce5528df8ca1890dbfe6426841992d0fb054bb16};
    logic [7:0] rcon_tab [0:9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                   8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    typedef struct packed {
        logic [3:0]   r;
        logic [127:0] k;
    } exp_t;
    exp_t sbq[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int pulses = 0;
    logic [127:0] got_rk [0:14];
    int           got_t  [0:14];
    logic [31:0]  ww     [0:59];
    logic [127:0] exp_rk [0:14];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sbox_tab[x[31:24]], sbox_tab[x[23:16]], sbox_tab[x[15:8]], sbox_tab[x[7:0]]};
    endfunction

    task automatic build_exp(input logic [255:0] k, input int nk);
        logic [31:0] t;
        int tot;
        tot = 4 * (nk + 7);
        for (int i = 0; i < nk; i++) ww[i] = k[255 - 32*i -: 32];
        for (int i = nk; i < tot; i++) begin
            t = ww[i-1];
            if (i % nk == 0)
                t = subw({t[23:0], t[31:24]}) ^ {rcon_tab[i/nk - 1], 24'h0};
            else if (nk == 8 && i % nk == 4)
                t = subw(t);
            ww[i] = ww[i-nk] ^ t;
        end
        for (int r = 0; r <= nk + 6; r++)
            exp_rk[r] = {ww[4*r], ww[4*r+1], ww[4*r+2], ww[4*r+3]};
    endtask

    task automatic push_exp(input int nk);
        exp_t e;
        for (int r = 0; r <= nk + 6; r++) begin
            e.r = 4'(r);
            e.k = exp_rk[r];
            sbq.push_back(e);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid) begin
            pulses = pulses + 1;
            if (out_round <= 4'd14) begin
                got_rk[out_round] = out_key;
                got_t[out_round]  = cyc;
            end
            if (sbq.size() == 0)
                chk("stray_vld", 128'(out_valid), 128'd0);
            else begin
                e = sbq.pop_front();
                chk("rk_round", 128'(out_round), 128'(e.r));
                chk("rk_key", out_key, e.k);
            end
        end
    end

    task automatic kick(input logic [1:0] kl, input logic [255:0] k);
        key_len = kl;
        key     = k;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int n0, input bit glitch, output int n);
        n = n0;
        while (!done && n < 200) begin
            if (glitch && n == 10) begin
                start   = 1'b1;
                key_len = 2'b10;
                key     = ~key;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            n++;
        end
        start = 1'b0;
    endtask

    task automatic do_run(input logic [1:0] kl, input logic [255:0] k, input int nk,
                          input logic [127:0] last, input int lat, input bit glitch);
        int p0;
        int n;
        build_exp(k, nk);
        push_exp(nk);
        p0      = pulses;
        rk_addr = 4'd0;
        kick(kl, k);
        chk("busy_set", 128'(busy), 128'd1);
        chk("kr_clr", 128'(key_ready), 128'd0);
        @(posedge clk);
        #1;
        chk("rd_busy", rk_data, 128'd0);
        wait_done(1, glitch, n);
        chk("done_lat", 128'(n), 128'(lat));
        chk("nr", 128'(nr), 128'(nk + 6));
        chk("kr_set", 128'(key_ready), 128'd1);
        chk("busy_clr", 128'(busy), 128'd0);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("pulses", 128'(pulses - p0), 128'(nk + 7));
        chk("last_rk", got_rk[nk + 6], last);
        rk_addr = 4'(nk + 6);
        @(posedge clk);
        #1;
        chk("rd_last", rk_data, last);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        int n, p0, seen;
        logic [255:0] kv;
        logic [127:0] leg_last;
        rst = 1'b1; start = 1'b0; key_len = 2'b00; key = '0; rk_addr = 4'd0;
        #12;
        chk("rst_ctl", 128'({busy, done, err, key_ready, out_valid, nr, out_round}), 128'd0);
        chk("rst_key", out_key, 128'd0);
        chk("rst_rd", rk_data, 128'd0);
        @(negedge clk);
        rst = 1'b0;

        do_run(2'b00, K128, 4, L128, 40, 1'b0);
        rk_addr = 4'd15;
        @(posedge clk);
        #1;
        chk("rd_oob", rk_data, 128'd0);

        do_run(2'b01, K192, 6, L192, 46, 1'b1);

        do_run(2'b10, K256, 8, L256, 52, 1'b0);
        chk("b2b_01", 128'(got_t[1] - got_t[0]), 128'd1);

        kick(2'b11, K128);
        chk("err_hi", 128'(err), 128'd1);
        chk("err_busy", 128'(busy), 128'd0);
        chk("err_kr", 128'(key_ready), 128'd1);
        chk("err_nr", 128'(nr), 128'd14);
        @(posedge clk);
        #1;
        chk("err_lo", 128'(err), 128'd0);

        kv = KLEG;
        build_exp(kv, 8);
        leg_last = exp_rk[14];
        do_run(2'b10, kv, 8, leg_last, 52, 1'b0);
        chk("leg_r0", got_rk[0], kv[255:128]);
        chk("leg_r1", got_rk[1], kv[127:0]);

        build_exp(K128, 4);
        push_exp(4);
        p0 = pulses;
        kick(2'b00, K128);
        wait_done(0, 1'b0, n);
        chk("dd_lat1", 128'(n), 128'd40);
        build_exp(K192, 6);
        push_exp(6);
        kick(2'b01, K192);
        chk("dd_busy", 128'(busy), 128'd1);
        wait_done(0, 1'b0, n);
        chk("dd_lat2", 128'(n), 128'd46);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("dd_pulses", 128'(pulses - p0), 128'd24);
        chk("dd_last", got_rk[12], L192);

        build_exp(K256, 8);
        push_exp(8);
        kick(2'b10, K256);
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mr_ctl", 128'({busy, done, err, key_ready, out_valid, nr, out_round}), 128'd0);
        chk("mr_key", out_key, 128'd0);
        chk("mr_rd", rk_data, 128'd0);
        sbq.delete();
        p0 = pulses;
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        repeat (70) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        chk("mr_nodone", 128'(seen), 128'd0);
        chk("mr_nopulse", 128'(pulses - p0), 128'd0);

        do_run(2'b00, K128, 4, L128, 40, 1'b0);

        chk("sb_empty", 128'(sbq.size()), 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
